// File: rtl/param_call_stack.sv
// param_call_stack: parametrised LIFO return-address stack with level/full/empty status and sticky errors.
// Optional CALL_STACK_WRAP_EN: push while full overwrites the oldest entry (circular mode) instead of dropping.
module param_call_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              underflow
);
    localparam int ADDR_W = LVL_W - 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_OVF,
        OP_UNF
    } op_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    op_e               op;

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        op = OP_HOLD;
        if (push && pop && !empty)
            op = OP_REPLACE;
        else if (push)
            op = full ? OP_OVF : OP_PUSH;
        else if (pop)
            op = empty ? OP_UNF : OP_POP;
    end

    always_comb begin
        wr_en   = (op == OP_PUSH) || (op == OP_REPLACE);
`ifdef CALL_STACK_WRAP_EN
        wr_en   = wr_en || (op == OP_OVF);
`endif
        wr_addr = (op == OP_REPLACE) ? ptr - ADDR_W'(1) : ptr;
    end

    // NOTE: the storage array is deliberately left out of reset; only the control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= data_in;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            level     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    ptr      <= ptr + ADDR_W'(1);
                    level    <= level + LVL_W'(1);
                    data_out <= data_in;
                end
                OP_REPLACE: data_out <= data_in;
                OP_POP: begin
                    ptr      <= ptr - ADDR_W'(1);
                    level    <= level - LVL_W'(1);
                    data_out <= (level >= LVL_W'(2)) ? mem[ptr - ADDR_W'(2)] : '0;
                end
`ifdef CALL_STACK_WRAP_EN
                OP_OVF: begin
                    ptr      <= ptr + ADDR_W'(1);
                    data_out <= data_in;
                end
`endif
                default: ;
            endcase
            // A new error wins over clr_err in the same cycle.
            overflow  <= (op == OP_OVF) || (overflow && !clr_err);
            underflow <= (op == OP_UNF) || (underflow && !clr_err);
        end
    end
endmodule

// File: tb/tb_param_call_stack.sv
// Scoreboard bench for param_call_stack: a 16x16 and a 24-bit x 4 instance share stimulus,
// each checked against an array-based LIFO reference model.
module tb_param_call_stack;
    logic        clk;
    logic        rst_n;
    logic        push, pop, clr_err;
    logic [23:0] din;

    logic [15:0] dout_a;
    logic        empty_a, full_a, ovf_a, unf_a;
    logic [4:0]  level_a;
    logic [23:0] dout_b;
    logic        empty_b, full_b, ovf_b, unf_b;
    logic [2:0]  level_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] dout;
        int          lvl;
        bit          empty;
        bit          full;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    logic [23:0] mstk [2][16];
    int          mlvl [2];
    bit          movf [2];
    bit          munf [2];

    param_call_stack #(.DATA_W(16), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(din[15:0]),
        .clr_err(clr_err), .data_out(dout_a), .empty(empty_a), .full(full_a),
        .level(level_a), .overflow(ovf_a), .underflow(unf_a)
    );

    param_call_stack #(.DATA_W(24), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .data_in(din),
        .clr_err(clr_err), .data_out(dout_b), .empty(empty_b), .full(full_b),
        .level(level_b), .overflow(ovf_b), .underflow(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mlvl[k] = 0;
            movf[k] = 0;
            munf[k] = 0;
        end
    endtask

    // LIFO semantics: index 0 is the oldest entry, mlvl-1 the top.
    task automatic model_step(input int k, input int depth, input bit p, input bit o,
                              input bit c, input logic [23:0] d);
        bit   ovf = 0;
        bit   unf = 0;
        exp_t e;
        if (p && o && mlvl[k] > 0) begin
            mstk[k][mlvl[k]-1] = d;
        end else if (p) begin
            if (mlvl[k] < depth) begin
                mstk[k][mlvl[k]] = d;
                mlvl[k]++;
            end else begin
                ovf = 1;
`ifdef CALL_STACK_WRAP_EN
                for (int i = 0; i < depth - 1; i++) mstk[k][i] = mstk[k][i+1];
                mstk[k][depth-1] = d;
`endif
            end
        end else if (o) begin
            if (mlvl[k] > 0) mlvl[k]--;
            else unf = 1;
        end
        movf[k] = ovf || (movf[k] && !c);
        munf[k] = unf || (munf[k] && !c);
        e.lvl   = mlvl[k];
        e.empty = (mlvl[k] == 0);
        e.full  = (mlvl[k] == depth);
        e.ovf   = movf[k];
        e.unf   = munf[k];
        e.dout  = (mlvl[k] == 0) ? 24'h0 : mstk[k][mlvl[k]-1];
        if (k == 0) exp_a.push_back(e);
        else exp_b.push_back(e);
    endtask

    task automatic cycle(input bit p, input bit o, input bit c, input logic [23:0] d);
        @(negedge clk);
        push    = p;
        pop     = o;
        clr_err = c;
        din     = d;
        @(posedge clk);
        model_step(0, 16, p, o, c, {8'h00, d[15:0]});
        model_step(1, 4, p, o, c, d);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_level_a"}, 32'(level_a), 0);
        check({tag, "_empty_a"}, 32'(empty_a), 1);
        check({tag, "_full_a"},  32'(full_a),  0);
        check({tag, "_dout_a"},  32'(dout_a),  0);
        check({tag, "_flags_a"}, 32'({ovf_a, unf_a}), 0);
        check({tag, "_level_b"}, 32'(level_b), 0);
        check({tag, "_dout_b"},  32'(dout_b),  0);
        check({tag, "_flags_b"}, 32'({ovf_b, unf_b}), 0);
    endtask

    // Monitor: registered outputs are compared half a cycle after each issuing edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check("a_data_out",  32'(dout_a),  32'(e.dout));
            check("a_level",     32'(level_a), 32'(e.lvl));
            check("a_empty",     32'(empty_a), 32'(e.empty));
            check("a_full",      32'(full_a),  32'(e.full));
            check("a_overflow",  32'(ovf_a),   32'(e.ovf));
            check("a_underflow", 32'(unf_a),   32'(e.unf));
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check("b_data_out",  32'(dout_b),  32'(e.dout));
            check("b_level",     32'(level_b), 32'(e.lvl));
            check("b_empty",     32'(empty_b), 32'(e.empty));
            check("b_full",      32'(full_b),  32'(e.full));
            check("b_overflow",  32'(ovf_b),   32'(e.ovf));
            check("b_underflow", 32'(unf_b),   32'(e.unf));
        end
    end

    initial begin
        rst_n = 1'b0; push = 0; pop = 0; clr_err = 0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Basic LIFO order
        cycle(1, 0, 0, 24'h001111);
        cycle(1, 0, 0, 24'h002222);
        cycle(1, 0, 0, 24'h003333);
        repeat (3) cycle(0, 1, 0, 24'h0);

        // Fill to DEPTH, then push while full, then drain past empty
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 24'h000100 + 24'(i));
        cycle(1, 0, 0, 24'h00BEEF);
        cycle(1, 1, 0, 24'h00CAFE);
        repeat (17) cycle(0, 1, 0, 24'h0);

        // Underflow, clear, and clear colliding with a new error
        cycle(0, 0, 1, 24'h0);
        cycle(0, 1, 0, 24'h0);
        cycle(0, 0, 1, 24'h0);
        cycle(0, 1, 0, 24'h0);
        cycle(0, 1, 1, 24'h0);
        cycle(0, 0, 1, 24'h0);

        // Replace-top, and push+pop on empty
        cycle(1, 0, 0, 24'h00AAAA);
        cycle(1, 0, 0, 24'h00BBBB);
        cycle(1, 1, 0, 24'h00CCCC);
        cycle(0, 1, 0, 24'h0);
        cycle(0, 1, 0, 24'h0);
        cycle(1, 1, 0, 24'h001234);
        cycle(0, 1, 0, 24'h0);

        // Asynchronous reset between edges with push asserted at level 5
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 24'h000500 + 24'(i));
        @(negedge clk);
        push = 1; pop = 0; clr_err = 0; din = 24'h00FFFF;
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        push = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 24'h005A5A);
        cycle(0, 1, 0, 24'h0);

        // Full-width data through the narrow-depth instance
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 24'hA50000 | 24'($urandom_range(0, 65535)));
        repeat (4) cycle(0, 1, 0, 24'h0);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 10, 24'($urandom));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_a.size() + exp_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
